// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the EX-stage multi-cycle unit sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StMulWait,
      StDivWait,
      StRelease
   } ex_state_t;

   typedef enum logic {
      UNIT_MUL,
      UNIT_DIV
   } unit_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ex_stall_ctrl_if.sv
// Pipeline-side signal bundle for the EX stall controller.
interface ex_stall_ctrl_if;

   logic       ID_EX_valid;
   logic       ID_EX_is_mul;
   logic       ID_EX_is_div;
   logic       ID_EX_memread;
   logic [4:0] ID_EX_rd;
   logic [4:0] IF_ID_rs1;
   logic [4:0] IF_ID_rs2;
   logic       IF_ID_uses_rs2;
   logic       flush;
   logic       mul_done;
   logic       div_done;

   logic       mul_start;
   logic       div_start;
   logic       unit_abort;
   logic       stall_pc;
   logic       hold_id_ex;
   logic       bubble_id_ex;
   logic       bubble_ex_mem;
   logic       mul_ready;
   logic       div_ready;
   logic       busy;
   logic       hang_err;

   modport master (
      output ID_EX_valid, ID_EX_is_mul, ID_EX_is_div, ID_EX_memread, ID_EX_rd,
             IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2, flush, mul_done, div_done,
      input  mul_start, div_start, unit_abort, stall_pc, hold_id_ex, bubble_id_ex,
             bubble_ex_mem, mul_ready, div_ready, busy, hang_err
   );

   modport slave (
      input  ID_EX_valid, ID_EX_is_mul, ID_EX_is_div, ID_EX_memread, ID_EX_rd,
             IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2, flush, mul_done, div_done,
      output mul_start, div_start, unit_abort, stall_pc, hold_id_ex, bubble_id_ex,
             bubble_ex_mem, mul_ready, div_ready, busy, hang_err
   );

endinterface

// File: rtl/ex_watchdog.sv
// Wait-cycle counter; expire flags the last permitted wait cycle.
module ex_watchdog #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = en & (cnt_q == LastCnt);

endmodule

// File: rtl/ex_stall_ctrl.sv
// Sequences the EX-stage multiplier/divider and drives stall, hold and bubble controls,
// plus load-use hazard detection between ID/EX and IF/ID.
module ex_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 7
) (
   input logic           clk,
   input logic           rst_n,
   ex_stall_ctrl_if.slave bus
);

   ex_state_t state_q, state_d;
   unit_t     unit_q, unit_d;
   logic      mul_ready_q, mul_ready_d;
   logic      div_ready_q, div_ready_d;
   logic      hang_err_q, hang_err_d;

   logic issue, in_wait, own_done, expire;
   logic mul_start, div_start, unit_abort, stall_wait;
   logic rd_match, load_use;

   assign issue   = (state_q == StIdle) & bus.ID_EX_valid
                    & (bus.ID_EX_is_mul | bus.ID_EX_is_div) & ~bus.flush;
   assign in_wait = (state_q == StMulWait) | (state_q == StDivWait);
   // Only the active unit's done counts; the other one is ignored.
   assign own_done = (state_q == StMulWait) ? bus.mul_done : bus.div_done;

   ex_watchdog #(
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
   ) u_watchdog (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (issue),
      .en    (in_wait),
      .expire(expire)
   );

   always_comb begin
      state_d     = state_q;
      unit_d      = unit_q;
      mul_ready_d = 1'b0;
      div_ready_d = 1'b0;
      hang_err_d  = hang_err_q;
      mul_start   = 1'b0;
      div_start   = 1'b0;
      unit_abort  = 1'b0;
      stall_wait  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (issue) begin
               stall_wait = 1'b1;
               if (bus.ID_EX_is_div) begin
                  div_start = 1'b1;
                  unit_d    = UNIT_DIV;
                  state_d   = StDivWait;
               end else begin
                  mul_start = 1'b1;
                  unit_d    = UNIT_MUL;
                  state_d   = StMulWait;
               end
            end
         end
         StMulWait, StDivWait: begin
            stall_wait = 1'b1;
            if (bus.flush) begin
               unit_abort = 1'b1;
               state_d    = StIdle;
            end else if (own_done) begin
               state_d = StRelease;
            end else if (expire) begin
               unit_abort = 1'b1;
               hang_err_d = 1'b1;
               state_d    = StIdle;
            end
         end
         StRelease: begin
            state_d = StIdle;
            if (!bus.flush) begin
               mul_ready_d = (unit_q == UNIT_MUL);
               div_ready_d = (unit_q == UNIT_DIV);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         unit_q      <= UNIT_MUL;
         mul_ready_q <= 1'b0;
         div_ready_q <= 1'b0;
         hang_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         unit_q      <= unit_d;
         mul_ready_q <= mul_ready_d;
         div_ready_q <= div_ready_d;
         hang_err_q  <= hang_err_d;
      end
   end

   assign rd_match = (bus.ID_EX_rd == bus.IF_ID_rs1)
                     | (bus.IF_ID_uses_rs2 & (bus.ID_EX_rd == bus.IF_ID_rs2));
   // Gating with ~issue keeps hold_id_ex and bubble_id_ex mutually exclusive.
   assign load_use = ((state_q == StIdle) | (state_q == StRelease)) & ~bus.flush & ~issue
                     & bus.ID_EX_valid & bus.ID_EX_memread & (bus.ID_EX_rd != REG_ZERO)
                     & rd_match;

   assign bus.mul_start     = mul_start;
   assign bus.div_start     = div_start;
   assign bus.unit_abort    = unit_abort;
   assign bus.stall_pc      = stall_wait | load_use;
   assign bus.hold_id_ex    = stall_wait;
   assign bus.bubble_id_ex  = load_use;
   assign bus.bubble_ex_mem = stall_wait;
   assign bus.mul_ready     = mul_ready_q;
   assign bus.div_ready     = div_ready_q;
   assign bus.busy          = (state_q != StIdle);
   assign bus.hang_err      = hang_err_q;

endmodule

// File: doc/ex_stall_ctrl.md
Name: ex_stall_ctrl

Overview:
- Sequences the multi-cycle multiply and divide units in the EX stage and generates the pipeline stall, hold and bubble controls around them.
- Detects load-use hazards between ID/EX and IF/ID.
- Produces the one-cycle `mul_ready`/`div_ready` qualifiers that the forwarding unit uses to select `mulres`/`divres` while the instruction sits in EX/MEM.
- Sits beside the hazard and forwarding logic in the core top level.

Parameters:
- TIMEOUT, 64: maximum WAIT cycles before the unit is declared hung.
- CNT_W, 7: watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ID_EX_valid  in  1  ID/EX holds a real (non-bubble) instruction
- ID_EX_is_mul  in  1  EX instruction is MUL*
- ID_EX_is_div  in  1  EX instruction is DIV*/REM*
- ID_EX_memread  in  1  EX instruction is a load
- ID_EX_rd  in  5  EX destination register
- IF_ID_rs1  in  5  decode source 1
- IF_ID_rs2  in  5  decode source 2
- IF_ID_uses_rs2  in  1  decode instruction reads rs2
- flush  in  1  branch/jump redirect; kills the EX instruction
- mul_done  in  1  multiplier result valid (level or pulse)
- div_done  in  1  divider result valid
- mul_start  out  1  one-cycle start pulse to multiplier
- div_start  out  1  one-cycle start pulse to divider
- unit_abort  out  1  one-cycle cancel to both units
- stall_pc  out  1  hold PC and IF/ID
- hold_id_ex  out  1  hold ID/EX
- bubble_id_ex  out  1  load NOP into ID/EX
- bubble_ex_mem  out  1  load NOP into EX/MEM
- mul_ready  out  1  EX/MEM holds a completed MUL result
- div_ready  out  1  EX/MEM holds a completed DIV result
- busy  out  1  FSM not IDLE
- hang_err  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - mul_ready, div_ready, hang_err = 0.
  - All combinational outputs evaluate to 0 in IDLE with no request.
- States: IDLE, MUL_WAIT, DIV_WAIT, RELEASE.
  - Encoded in `ex_state_t`.
  - `unit_t` register records which unit is active.
- Issue condition: IDLE, `ID_EX_valid`, `(is_mul|is_div)`, `!flush`.
  - Issue cycle outputs: start pulse for the selected unit, stall_pc=1, hold_id_ex=1, bubble_ex_mem=1.
  - Next state: MUL_WAIT or DIV_WAIT. Counter cleared.
  - If is_mul and is_div are both set, divide wins.
- MUL_WAIT / DIV_WAIT:
  - stall_pc=1, hold_id_ex=1, bubble_ex_mem=1 every cycle.
  - Counter increments each cycle.
  - done is sampled only in these states. Done arriving in the issue cycle is ignored. The other unit's done is ignored.
  - Own done=1 -> RELEASE.
  - flush=1 -> unit_abort=1 this cycle, -> IDLE, no ready.
  - flush has priority over done in the same cycle.
  - Counter==TIMEOUT-1 and no done -> unit_abort=1, hang_err<=1 (sticky until reset), -> IDLE.
- RELEASE:
  - All stall outputs 0; the instruction advances into EX/MEM at the clock edge.
  - Next cycle the matching ready register is 1 for exactly one cycle.
  - Next state IDLE.
  - flush in RELEASE: no ready is asserted.
- Ready rules:
  - mul_ready and div_ready are never both 1.
  - Each is low at all other times.
  - A new issue in the same cycle a ready is high is legal.
- Load-use hazard:
  - Condition: `ID_EX_valid & ID_EX_memread & ID_EX_rd!=0 & (ID_EX_rd==IF_ID_rs1 | (IF_ID_uses_rs2 & ID_EX_rd==IF_ID_rs2))`.
  - Evaluated only in IDLE/RELEASE.
  - Response: stall_pc=1, bubble_id_ex=1 for one cycle. Needs no state.
  - Suppressed when flush=1. Never coincides with an issue, since a load is not a mul/div.
- Output exclusivity: hold_id_ex and bubble_id_ex are never both 1.
- busy = (state != IDLE).
- Mid-operation reset: returns to IDLE immediately. No start, abort or ready pulse is generated.

Decomposition:
- Package `pipe_ctrl_pkg`:
  - `ex_state_t` enum.
  - `unit_t` enum {UNIT_MUL, UNIT_DIV}.
  - `REG_ZERO` constant.
- Sub-module `ex_watchdog`:
  - Inputs: clr, en.
  - Output: expire at TIMEOUT-1.
  - Parameters: TIMEOUT, CNT_W.
  - Contains the counter.
- Hazard compare is inline in the top module.

Test Plan:
- MUL issue, mul_done asserted 3 cycles after mul_start -> mul_start 1 cycle, stalls for 4 cycles (issue + 3 WAIT), one RELEASE cycle, then mul_ready=1 for exactly 1 cycle.
- DIV issue with both is_mul=1 and is_div=1, div_done after 33 cycles -> only div_start asserted, div_ready pulses once, mul_ready stays 0 throughout.
- Load x5 in EX, decode reads rs2=x5 with uses_rs2=1 -> stall_pc=1 and bubble_id_ex=1 for one cycle. Same case with rd=x0 -> no stall.
- flush on 2nd WAIT cycle with mul_done in the same cycle -> unit_abort=1, state IDLE next cycle, no mul_ready, stalls drop.
- TIMEOUT=8, divider never completes -> unit_abort at 8th WAIT cycle, hang_err=1 and held, busy=0 afterward.
- rst_n deasserted mid-DIV_WAIT -> all outputs 0 asynchronously. After release, idle with no spurious start or ready.
